mc_core_p: RTL and testbench
============================

Name: mc_core_p

Overview:
- Parametrised second-generation multi-cycle load/store core for the synthesizer control path. Executes the existing 16-bit, 4-bit-opcode ISA.
- Adds configurable data/address width and a req/ack memory handshake with wait states.
- Adds signed PC-relative branches, a HALT opcode and a full register-file export bus.
- Sits between instruction/data memory and the PWM/I2C register consumers, which tap regs_flat.

Parameters:
- DATA_W, 16, register/data width; must be >= 16.
- ADDR_W, 10, memory address width; PC width.
- LINK_REG, 5, register written by jump-and-link.
- RESET_PC, 0, PC value after reset.

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous active-high reset
- mem_req  out  1  memory request; held high until acked
- mem_we  out  1  write qualifier for the current request
- mem_addr  out  ADDR_W  request address
- mem_wdata  out  DATA_W  store data
- mem_rdata  in  DATA_W  read data; valid in the cycle mem_ack=1; instruction = low 16 bits
- mem_ack  in  1  completes the request; may be high in the same cycle as mem_req
- halted  out  1  core stopped on HALT
- regs_flat  out  16*DATA_W  r0..r15 concatenated, r0 in the LSBs
- state_dbg  out  3  current FSM state encoding

Behaviour:
- Reset: rst is sampled on posedge clk only.
  - State=FETCH, PC=RESET_PC, all 16 regs=0, flags=0, IR=0, halted=0.
  - mem_req, mem_we, mem_addr and mem_wdata are all 0 in the reset cycle.
  - Reset mid-request abandons the request; memory must tolerate a dropped req.
- States: FETCH=0, DECODE=1, EXEC=2, MEM=3, HALT=4.
- FETCH:
  - mem_req=1, mem_we=0, mem_addr=PC.
  - On mem_ack: IR<=mem_rdata[15:0], go to DECODE. Otherwise stay; outputs are stable while waiting.
- DECODE: one cycle. Latch operands: A=R[IR[11:8]], B=R[IR[7:4]], C=R[IR[3:0]]. Then:
  - LW/SW -> MEM.
  - HALT -> HALT.
  - All others -> EXEC.
- EXEC: one cycle, then FETCH. Default next PC = PC+1, mod 2^ADDR_W.
  - LI (0100): R[11:8] <= zero-extended imm[7:0].
  - OUI (0101): R[11:8] <= A | (imm<<8).
  - AND, OR, ADD (0110, 0111, 1010): R[3:0] is NOT the destination. Destination = IR[11:8], sources = B and C.
    - ADD wraps mod 2^DATA_W.
  - SUB (1011): dest = IR[11:8]; result = B-C, or 0 if C > B (saturating).
  - SLL/SLR (1000/1001): dest = IR[11:8]; result = B shifted logically by IR[3:0].
  - NOT (1110): dest = IR[11:8]; result = ~B.
  - LT (1100): flag[1] <= (B < C), unsigned. No register write.
  - EQ (1101): flag[0] <= (B == C). No register write.
  - flag[7:2] read as 0.
  - BR (0011): if IR[11] == flag[IR[10:8]], PC <= PC + sign-extended imm[7:0]; else PC+1. Target wraps mod 2^ADDR_W.
  - JMP (0010): fields are cond=IR[11], cb=IR[10], fidx=IR[9:7], jal=IR[6], target reg IR[3:0].
    - Taken if cond=0, or if cb == flag[fidx]. Taken: PC <= C[ADDR_W-1:0]; else PC+1.
    - If jal=1, R[LINK_REG] <= PC+1 (zero-extended), regardless of whether the jump is taken.
    - If the target reg equals LINK_REG, the jump uses the pre-write value.
- MEM: address = (A+B) low ADDR_W bits. mem_req=1; mem_we=1 for SW.
  - SW: mem_wdata = C.
  - LW: on ack, R[IR[3:0]] <= mem_rdata.
  - Stays in MEM until mem_ack, then PC+1 and FETCH.
- HALT (1111): halted=1, mem_req=0. Stays until rst.
- Latency with zero-wait memory (ack in the same cycle):
  - ALU, BR and JMP instructions: 3 cycles.
  - LW/SW: 3 cycles.
  - Each wait cycle adds 1.
- Register writes take effect on the EXEC/MEM exit edge and are visible on regs_flat the next cycle.
- Only one register write is possible per instruction.
- mem_ack while mem_req=0 is ignored.

Test Plan:
- LI r1,0x12; OUI r1,0x34 -> regs_flat r1 = 0x3412; each instruction takes 3 cycles with ack tied high.
- r2=5, r3=7: SUB r4,r2,r3 -> r4=0. ADD r4,r3,r2 -> r4=12. LT r2,r3 then BR cb=1 fidx=1 imm=0xFE at PC=10 -> PC=8.
- SW of r3 (0x0007) to address r1+r2 with ack delayed 3 cycles:
  - mem_req held 4 cycles, mem_addr constant, mem_we=1.
  - Then LW back into r6 -> r6=7.
- JMP cond=0, jal=1, target r7=0x40 at PC=0x20 -> PC=0x40, r5=0x21. Conditional JMP with flag mismatch -> PC=0x21, r5 still written.
- rst pulsed while in a FETCH wait state -> next cycle: state 0, PC=RESET_PC, all regs 0, mem_req=0 during the reset cycle.
- HALT at PC=3 -> halted=1 and mem_req stays 0 for 20 cycles. ADDR_W=4 build: BR imm=+3 from PC=14 -> PC=1 (wrap).

Source files
------------

// File: rtl/mc_core_p_if.sv
// Memory request/acknowledge bus between mc_core_p (master) and the
// instruction/data memory (slave).
interface mc_core_p_if #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 10
);
   logic              mem_req;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;
   logic              mem_ack;

   modport master (
      output mem_req, mem_we, mem_addr, mem_wdata,
      input  mem_rdata, mem_ack
   );

   modport slave (
      input  mem_req, mem_we, mem_addr, mem_wdata,
      output mem_rdata, mem_ack
   );
endinterface

// File: rtl/mc_core_p.sv
// Multi-cycle load/store core: FETCH -> DECODE -> EXEC/MEM over a req/ack
// memory bus, 16 registers exported flat for the PWM/I2C register taps.
module mc_core_p #(
   parameter int                DATA_W   = 16,
   parameter int                ADDR_W   = 10,
   parameter int                LINK_REG = 5,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic                 clk,
   input  logic                 rst,
   mc_core_p_if.master          mem,
   output logic                 halted,
   output logic [16*DATA_W-1:0] regs_flat,
   output logic [2:0]           state_dbg
);

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_HALT   = 3'd4
   } state_t;

   localparam logic [3:0] OP_LW   = 4'h0;
   localparam logic [3:0] OP_SW   = 4'h1;
   localparam logic [3:0] OP_JMP  = 4'h2;
   localparam logic [3:0] OP_BR   = 4'h3;
   localparam logic [3:0] OP_LI   = 4'h4;
   localparam logic [3:0] OP_OUI  = 4'h5;
   localparam logic [3:0] OP_AND  = 4'h6;
   localparam logic [3:0] OP_OR   = 4'h7;
   localparam logic [3:0] OP_SLL  = 4'h8;
   localparam logic [3:0] OP_SLR  = 4'h9;
   localparam logic [3:0] OP_ADD  = 4'hA;
   localparam logic [3:0] OP_SUB  = 4'hB;
   localparam logic [3:0] OP_LT   = 4'hC;
   localparam logic [3:0] OP_EQ   = 4'hD;
   localparam logic [3:0] OP_NOT  = 4'hE;
   localparam logic [3:0] OP_HALT = 4'hF;

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   pc_q, pc_d;
   logic [15:0]         ir_q, ir_d;
   logic [DATA_W-1:0]   a_q, a_d, b_q, b_d, c_q, c_d;
   logic [1:0]          flags_q, flags_d;
   logic [DATA_W-1:0]   regs_q [16];

   logic                rf_we;
   logic [3:0]          rf_waddr;
   logic [DATA_W-1:0]   rf_wdata;

   logic [3:0]          op, ra, rb, rc;
   logic [7:0]          imm;
   logic [7:0]          flag_vec;
   logic [ADDR_W-1:0]   pc_inc;
   logic [ADDR_W-1:0]   eff_addr;

   function automatic logic [DATA_W-1:0] sat_sub(input logic [DATA_W-1:0] minu,
                                                 input logic [DATA_W-1:0] subt);
      return (subt > minu) ? '0 : (minu - subt);
   endfunction

   // Signed 8-bit displacement added modulo 2^ADDR_W.
   function automatic logic [ADDR_W-1:0] br_target(input logic [ADDR_W-1:0] pc,
                                                    input logic [7:0]        disp);
      logic signed [ADDR_W+7:0] off;
      off = signed'({{ADDR_W{disp[7]}}, disp});
      return pc + off[ADDR_W-1:0];
   endfunction

   assign op       = ir_q[15:12];
   assign ra       = ir_q[11:8];
   assign rb       = ir_q[7:4];
   assign rc       = ir_q[3:0];
   assign imm      = ir_q[7:0];
   assign flag_vec = {6'b000000, flags_q};
   assign pc_inc   = pc_q + ADDR_W'(1);
   assign eff_addr = a_q[ADDR_W-1:0] + b_q[ADDR_W-1:0];

   // ---------------------------------------------------------------- state register
   always_ff @(posedge clk) begin
      if (rst) state_q <= S_FETCH;
      else     state_q <= state_d;
   end

   // ---------------------------------------------------------------- next state
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_FETCH:  if (mem.mem_ack) state_d = S_DECODE;
         S_DECODE: begin
            if (op == OP_LW || op == OP_SW) state_d = S_MEM;
            else if (op == OP_HALT)         state_d = S_HALT;
            else                            state_d = S_EXEC;
         end
         S_EXEC:   state_d = S_FETCH;
         S_MEM:    if (mem.mem_ack) state_d = S_FETCH;
         S_HALT:   state_d = S_HALT;
         default:  state_d = S_FETCH;
      endcase
   end

   // ---------------------------------------------------------------- outputs
   // Bus outputs are forced to zero while rst is high, so a reset landing
   // mid-request drops the request in that same cycle.
   always_comb begin
      mem.mem_req   = 1'b0;
      mem.mem_we    = 1'b0;
      mem.mem_addr  = '0;
      mem.mem_wdata = '0;
      if (!rst) begin
         case (state_q)
            S_FETCH: begin
               mem.mem_req  = 1'b1;
               mem.mem_addr = pc_q;
            end
            S_MEM: begin
               mem.mem_req  = 1'b1;
               mem.mem_we   = (op == OP_SW);
               mem.mem_addr = eff_addr;
               if (op == OP_SW) mem.mem_wdata = c_q;
            end
            default: ;
         endcase
      end
   end

   assign halted    = (state_q == S_HALT);
   assign state_dbg = state_q;

   // ---------------------------------------------------------------- datapath next state
   always_comb begin
      pc_d     = pc_q;
      ir_d     = ir_q;
      a_d      = a_q;
      b_d      = b_q;
      c_d      = c_q;
      flags_d  = flags_q;
      rf_we    = 1'b0;
      rf_waddr = ra;
      rf_wdata = '0;
      case (state_q)
         S_FETCH:  if (mem.mem_ack) ir_d = mem.mem_rdata[15:0];
         S_DECODE: begin
            a_d = regs_q[ra];
            b_d = regs_q[rb];
            c_d = regs_q[rc];
         end
         S_EXEC: begin
            pc_d = pc_inc;
            case (op)
               OP_LI:  begin rf_we = 1'b1; rf_wdata = DATA_W'(imm); end
               OP_OUI: begin rf_we = 1'b1; rf_wdata = a_q | (DATA_W'(imm) << 8); end
               OP_AND: begin rf_we = 1'b1; rf_wdata = b_q & c_q; end
               OP_OR:  begin rf_we = 1'b1; rf_wdata = b_q | c_q; end
               OP_ADD: begin rf_we = 1'b1; rf_wdata = b_q + c_q; end
               OP_SUB: begin rf_we = 1'b1; rf_wdata = sat_sub(b_q, c_q); end
               OP_SLL: begin rf_we = 1'b1; rf_wdata = b_q << rc; end
               OP_SLR: begin rf_we = 1'b1; rf_wdata = b_q >> rc; end
               OP_NOT: begin rf_we = 1'b1; rf_wdata = ~b_q; end
               OP_LT:  flags_d[1] = (b_q < c_q);
               OP_EQ:  flags_d[0] = (b_q == c_q);
               OP_BR:  if (ir_q[11] == flag_vec[ir_q[10:8]]) pc_d = br_target(pc_q, imm);
               OP_JMP: begin
                  // c_q was latched in DECODE, so a jump through the link
                  // register uses its value from before this instruction's link.
                  if (!ir_q[11] || (ir_q[10] == flag_vec[ir_q[9:7]]))
                     pc_d = c_q[ADDR_W-1:0];
                  if (ir_q[6]) begin
                     rf_we    = 1'b1;
                     rf_waddr = 4'(LINK_REG);
                     rf_wdata = DATA_W'(pc_inc);
                  end
               end
               default: ;
            endcase
         end
         S_MEM: begin
            if (mem.mem_ack) begin
               pc_d = pc_inc;
               if (op == OP_LW) begin
                  rf_we    = 1'b1;
                  rf_waddr = rc;
                  rf_wdata = mem.mem_rdata;
               end
            end
         end
         default: ;
      endcase
   end

   // ---------------------------------------------------------------- architectural state
   always_ff @(posedge clk) begin
      if (rst) begin
         pc_q    <= RESET_PC;
         ir_q    <= '0;
         flags_q <= '0;
         for (int i = 0; i < 16; i++) regs_q[i] <= '0;
      end else begin
         pc_q    <= pc_d;
         ir_q    <= ir_d;
         flags_q <= flags_d;
         if (rf_we) regs_q[rf_waddr] <= rf_wdata;
      end
   end

   // Operand latches carry data only and need no reset.
   always_ff @(posedge clk) begin
      a_q <= a_d;
      b_q <= b_d;
      c_q <= c_d;
   end

   for (genvar g = 0; g < 16; g++) begin : g_flat
      assign regs_flat[g*DATA_W +: DATA_W] = regs_q[g];
   end

endmodule

// File: tb/tb_mc_core_p.sv
// Directed bench for mc_core_p: small programs in a wait-state memory model,
// plus a 4-bit-address build for PC wrap-around.
module tb_mc_core_p;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   mc_core_p_if #(.DATA_W(16), .ADDR_W(10)) bus ();
   mc_core_p_if #(.DATA_W(16), .ADDR_W(4))  bus4 ();

   logic         halted, halted4;
   logic [255:0] regs_flat, regs_flat4;
   logic [2:0]   state_dbg, state_dbg4;

   mc_core_p #(.DATA_W(16), .ADDR_W(10), .LINK_REG(5), .RESET_PC(10'd0)) dut (
      .clk(clk), .rst(rst), .mem(bus),
      .halted(halted), .regs_flat(regs_flat), .state_dbg(state_dbg)
   );

   mc_core_p #(.DATA_W(16), .ADDR_W(4), .LINK_REG(5), .RESET_PC(4'd0)) dut4 (
      .clk(clk), .rst(rst), .mem(bus4),
      .halted(halted4), .regs_flat(regs_flat4), .state_dbg(state_dbg4)
   );

   // Memory model: ack after a programmable number of wait cycles.
   logic [15:0] mem [0:1023];
   int          fetch_wait = 1000;
   int          mem_wait   = 0;
   int          wcnt       = 0;
   logic        ld_en      = 1'b0;
   logic [9:0]  ld_addr    = '0;
   logic [15:0] ld_data    = '0;

   assign bus.mem_ack   = bus.mem_req && (wcnt == ((state_dbg == 3'd3) ? mem_wait : fetch_wait));
   assign bus.mem_rdata = mem[bus.mem_addr];

   always @(posedge clk) begin
      if (bus.mem_req && !bus.mem_ack) wcnt <= wcnt + 1;
      else                             wcnt <= 0;
      if (ld_en) mem[ld_addr] <= ld_data;
      else if (bus.mem_req && bus.mem_ack && bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
   end

   function automatic logic [15:0] prog4(input logic [3:0] a);
      case (a)
         4'd0:    return 16'h370E;   // BR always (flag7==0), +14
         4'd14:   return 16'h3703;   // BR always, +3 -> wraps to 1
         default: return 16'hF000;   // HALT
      endcase
   endfunction

   assign bus4.mem_ack   = bus4.mem_req;
   assign bus4.mem_rdata = prog4(bus4.mem_addr);

   int n_chk  = 0;
   int n_fail = 0;

   function automatic logic [15:0] rr(input int i);
      return regs_flat[i*16 +: 16];
   endfunction

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic load(input logic [9:0] a, input logic [15:0] d);
      ld_en = 1'b1; ld_addr = a; ld_data = d;
      @(posedge clk); #1;
      ld_en = 1'b0;
   endtask

   task automatic test_reset();
      @(posedge clk); #1;
      n_chk++; if (bus.mem_req !== 1'b0) begin n_fail++; $display("FAIL rst_req: got %b want 0", bus.mem_req); end
      n_chk++; if ({bus.mem_we, bus.mem_addr, bus.mem_wdata} !== '0) begin n_fail++; $display("FAIL rst_bus: got %b/%h/%h want 0", bus.mem_we, bus.mem_addr, bus.mem_wdata); end
      @(posedge clk); #1;
      rst = 1'b0; #1;
      n_chk++; if (state_dbg !== 3'd0) begin n_fail++; $display("FAIL rst_state: got %0d want 0", state_dbg); end
      n_chk++; if (regs_flat !== '0) begin n_fail++; $display("FAIL rst_regs: got %h want 0", regs_flat); end
      n_chk++; if (halted !== 1'b0) begin n_fail++; $display("FAIL rst_halted: got %b want 0", halted); end
      cyc(2);
      n_chk++; if ({bus.mem_req, bus.mem_we, bus.mem_addr} !== {1'b1, 1'b0, 10'd0}) begin n_fail++; $display("FAIL fetch_wait_stable: got req=%b we=%b addr=%h want 1/0/000", bus.mem_req, bus.mem_we, bus.mem_addr); end
   endtask

   task automatic test_li_oui();
      rst = 1'b1; fetch_wait = 0; mem_wait = 0;
      load(0, 16'h4112); load(1, 16'h5134); load(2, 16'hF000);
      rst = 1'b0;
      cyc(3);
      n_chk++; if (bus.mem_addr !== 10'd1 || state_dbg !== 3'd0) begin n_fail++; $display("FAIL li_latency: got addr=%h st=%0d want 001/0", bus.mem_addr, state_dbg); end
      n_chk++; if (rr(1) !== 16'h0012) begin n_fail++; $display("FAIL li_r1: got %h want 0012", rr(1)); end
      cyc(3);
      n_chk++; if (bus.mem_addr !== 10'd2 || state_dbg !== 3'd0) begin n_fail++; $display("FAIL oui_latency: got addr=%h st=%0d want 002/0", bus.mem_addr, state_dbg); end
      n_chk++; if (rr(1) !== 16'h3412) begin n_fail++; $display("FAIL oui_r1: got %h want 3412", rr(1)); end
   endtask

   task automatic test_alu_br();
      rst = 1'b1; fetch_wait = 0; mem_wait = 0;
      load(0, 16'h4205); load(1, 16'h4307); load(2, 16'h4455);
      load(3, 16'hB423); load(4, 16'hA432); load(5, 16'hC023);
      load(6, 16'h3805); load(7, 16'hBB32); load(8, 16'hE820);
      load(9, 16'h8934); load(10, 16'h39FE);
      rst = 1'b0;
      cyc(9);
      n_chk++; if (rr(4) !== 16'h0055) begin n_fail++; $display("FAIL li_r4: got %h want 0055", rr(4)); end
      cyc(3);
      n_chk++; if (rr(4) !== 16'h0000) begin n_fail++; $display("FAIL sub_sat: got %h want 0000", rr(4)); end
      cyc(3);
      n_chk++; if (rr(4) !== 16'h000C) begin n_fail++; $display("FAIL add: got %h want 000c", rr(4)); end
      cyc(6);
      n_chk++; if (bus.mem_addr !== 10'd7 || state_dbg !== 3'd0) begin n_fail++; $display("FAIL br_not_taken: got addr=%h st=%0d want 007/0", bus.mem_addr, state_dbg); end
      cyc(12);
      n_chk++; if (bus.mem_addr !== 10'd8 || state_dbg !== 3'd0) begin n_fail++; $display("FAIL br_back: got addr=%h st=%0d want 008/0", bus.mem_addr, state_dbg); end
      n_chk++; if (rr(11) !== 16'h0002) begin n_fail++; $display("FAIL sub_pos: got %h want 0002", rr(11)); end
      n_chk++; if (rr(8) !== 16'hFFFA) begin n_fail++; $display("FAIL not: got %h want fffa", rr(8)); end
      n_chk++; if (rr(9) !== 16'h0070) begin n_fail++; $display("FAIL sll: got %h want 0070", rr(9)); end
   endtask

   task automatic test_mem_wait();
      int   cnt;
      logic stable;
      rst = 1'b1; fetch_wait = 0; mem_wait = 3;
      load(0, 16'h4120); load(1, 16'h4210); load(2, 16'h4307);
      load(3, 16'h1123); load(4, 16'h0126); load(5, 16'hF000);
      load(10'h030, 16'h0000);
      rst = 1'b0;
      cyc(11);
      n_chk++; if (state_dbg !== 3'd3) begin n_fail++; $display("FAIL sw_enter_mem: got %0d want 3", state_dbg); end
      cnt = 0; stable = 1'b1;
      for (int i = 0; i < 8 && state_dbg == 3'd3; i++) begin
         cnt++;
         if (!(bus.mem_req === 1'b1 && bus.mem_we === 1'b1 && bus.mem_addr === 10'h030 && bus.mem_wdata === 16'h0007))
            stable = 1'b0;
         cyc(1);
      end
      n_chk++; if (cnt != 4) begin n_fail++; $display("FAIL sw_req_cycles: got %0d want 4", cnt); end
      n_chk++; if (stable !== 1'b1) begin n_fail++; $display("FAIL sw_bus_stable: got %b want 1", stable); end
      n_chk++; if (mem[10'h030] !== 16'h0007) begin n_fail++; $display("FAIL sw_data: got %h want 0007", mem[10'h030]); end
      cyc(6);
      n_chk++; if (bus.mem_addr !== 10'd5 || state_dbg !== 3'd0) begin n_fail++; $display("FAIL lw_latency: got addr=%h st=%0d want 005/0", bus.mem_addr, state_dbg); end
      n_chk++; if (rr(6) !== 16'h0007) begin n_fail++; $display("FAIL lw_r6: got %h want 0007", rr(6)); end
   endtask

   task automatic test_jmp_link();
      rst = 1'b1; fetch_wait = 0; mem_wait = 0;
      load(0, 16'h4740); load(1, 16'h4599); load(2, 16'h371E);
      load(10'h020, 16'h2047); load(10'h040, 16'h2C47); load(10'h041, 16'h2045);
      rst = 1'b0;
      cyc(9);
      n_chk++; if (bus.mem_addr !== 10'h020) begin n_fail++; $display("FAIL br_fwd: got %h want 020", bus.mem_addr); end
      cyc(3);
      n_chk++; if (bus.mem_addr !== 10'h040) begin n_fail++; $display("FAIL jal_target: got %h want 040", bus.mem_addr); end
      n_chk++; if (rr(5) !== 16'h0021) begin n_fail++; $display("FAIL jal_link: got %h want 0021", rr(5)); end
      cyc(3);
      n_chk++; if (bus.mem_addr !== 10'h041) begin n_fail++; $display("FAIL jmp_not_taken: got %h want 041", bus.mem_addr); end
      n_chk++; if (rr(5) !== 16'h0041) begin n_fail++; $display("FAIL jmp_nt_link: got %h want 0041", rr(5)); end
      cyc(3);
      n_chk++; if (bus.mem_addr !== 10'h041) begin n_fail++; $display("FAIL jmp_link_prewrite: got %h want 041", bus.mem_addr); end
      n_chk++; if (rr(5) !== 16'h0042) begin n_fail++; $display("FAIL jmp_link_reg: got %h want 0042", rr(5)); end
   endtask

   task automatic test_reset_mid();
      fetch_wait = 1000;
      cyc(4);
      n_chk++; if (state_dbg !== 3'd0 || bus.mem_req !== 1'b1 || bus.mem_addr !== 10'h041) begin n_fail++; $display("FAIL mid_waiting: got st=%0d req=%b addr=%h want 0/1/041", state_dbg, bus.mem_req, bus.mem_addr); end
      rst = 1'b1; #1;
      n_chk++; if (bus.mem_req !== 1'b0 || bus.mem_addr !== 10'd0) begin n_fail++; $display("FAIL mid_rst_bus: got req=%b addr=%h want 0/000", bus.mem_req, bus.mem_addr); end
      @(posedge clk); #1;
      rst = 1'b0; #1;
      n_chk++; if (state_dbg !== 3'd0 || bus.mem_addr !== 10'd0) begin n_fail++; $display("FAIL mid_rst_pc: got st=%0d addr=%h want 0/000", state_dbg, bus.mem_addr); end
      n_chk++; if (regs_flat !== '0) begin n_fail++; $display("FAIL mid_rst_regs: got %h want 0", regs_flat); end
   endtask

   task automatic test_halt();
      int bad;
      rst = 1'b1; fetch_wait = 0; mem_wait = 0;
      load(0, 16'h4101); load(1, 16'h4202); load(2, 16'h4303); load(3, 16'hF000);
      rst = 1'b0;
      cyc(11);
      n_chk++; if (halted !== 1'b1 || state_dbg !== 3'd4) begin n_fail++; $display("FAIL halt_enter: got h=%b st=%0d want 1/4", halted, state_dbg); end
      n_chk++; if (rr(3) !== 16'h0003) begin n_fail++; $display("FAIL halt_r3: got %h want 0003", rr(3)); end
      bad = 0;
      for (int i = 0; i < 20; i++) begin
         cyc(1);
         if (bus.mem_req !== 1'b0 || halted !== 1'b1) bad++;
      end
      n_chk++; if (bad != 0) begin n_fail++; $display("FAIL halt_hold: got %0d bad cycles want 0", bad); end
   endtask

   task automatic test_addr_wrap();
      rst = 1'b1; cyc(1); rst = 1'b0;
      cyc(3);
      n_chk++; if (bus4.mem_addr !== 4'd14 || state_dbg4 !== 3'd0) begin n_fail++; $display("FAIL w4_br14: got addr=%h st=%0d want e/0", bus4.mem_addr, state_dbg4); end
      cyc(3);
      n_chk++; if (bus4.mem_addr !== 4'd1 || state_dbg4 !== 3'd0) begin n_fail++; $display("FAIL w4_wrap: got addr=%h st=%0d want 1/0", bus4.mem_addr, state_dbg4); end
      cyc(3);
      n_chk++; if (halted4 !== 1'b1 || bus4.mem_req !== 1'b0) begin n_fail++; $display("FAIL w4_halt: got h=%b req=%b want 1/0", halted4, bus4.mem_req); end
      n_chk++; if (regs_flat4 !== '0 || bus4.mem_we !== 1'b0 || bus4.mem_wdata !== '0) begin n_fail++; $display("FAIL w4_quiet: got regs=%h we=%b wd=%h want 0", regs_flat4, bus4.mem_we, bus4.mem_wdata); end
   endtask

   initial begin
      test_reset();
      test_li_oui();
      test_alu_br();
      test_mem_wait();
      test_jmp_link();
      test_reset_mid();
      test_halt();
      test_addr_wrap();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
